// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, single-outstanding imem fetch and IF/ID pipeline register
module fetch_stage #(
  parameter int                 IMEM_AW  = 32,
  parameter logic [IMEM_AW-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               id_stall,
  input  logic               redirect,
  input  logic [IMEM_AW-1:0] redirect_pc,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [IMEM_AW-1:0] id_pc,
  output logic [IMEM_AW-1:0] id_pc_plus4,
  output logic [5:0]         id_opcode,
  output logic [5:0]         id_funct
);
  typedef enum logic [1:0] {FETCH, WAIT, FULL} state_t;
  localparam logic [IMEM_AW-1:0] ALIGN = ~IMEM_AW'(3);
  localparam logic [IMEM_AW-1:0] FOUR  = IMEM_AW'(4);
  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic               kill_q, kill_d;
  logic [31:0]        skid_instr_q, skid_instr_d;
  logic [IMEM_AW-1:0] skid_pc_q, skid_pc_d;
  logic               id_valid_q, id_valid_d;
  logic [31:0]        id_instr_q, id_instr_d;
  logic [IMEM_AW-1:0] id_pc_q, id_pc_d;
  logic [IMEM_AW-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic               can_load;
  assign can_load    = !id_valid_q || !id_stall;
  assign imem_req    = state_q == FETCH && !reset;
  assign imem_addr   = pc_q & ALIGN;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_opcode   = id_instr_q[31:26];
  assign id_funct    = id_instr_q[5:0];
  // Next state: fetch handshake, IF/ID load/drain, skid fill/drain; redirect overrides everything
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    id_valid_d    = id_valid_q && id_stall;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    case (state_q)
      FETCH: state_d = imem_ack ? WAIT : FETCH;
      WAIT: begin
        if (imem_rvalid && kill_q) begin
          kill_d  = 1'b0;
          state_d = FETCH;
        end else if (imem_rvalid && can_load) begin
          id_valid_d    = 1'b1;
          id_instr_d    = imem_rdata;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_q + FOUR;
          pc_d          = pc_q + FOUR;
          state_d       = FETCH;
        end else if (imem_rvalid) begin
          skid_instr_d = imem_rdata;
          skid_pc_d    = pc_q;
          pc_d         = pc_q + FOUR;
          state_d      = FULL;
        end
      end
      FULL: begin
        if (!id_stall) begin
          id_valid_d    = 1'b1;
          id_instr_d    = skid_instr_q;
          id_pc_d       = skid_pc_q;
          id_pc_plus4_d = skid_pc_q + FOUR;
          state_d       = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    if (redirect) begin
      pc_d       = redirect_pc & ALIGN;
      id_valid_d = 1'b0;
      state_d    = (state_q == FETCH && imem_ack) || (state_q == WAIT && !imem_rvalid) ? WAIT : FETCH;
      kill_d     = state_d == WAIT;
    end
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end
  // A pending request keeps its address unless a redirect retargets it
  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    imem_req && !imem_ack && !redirect |=> $stable(imem_addr));
  // Requests are only issued from FETCH
  a_no_req: assert property (@(posedge clk) disable iff (reset)
    state_q != FETCH |-> !imem_req);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector check of fetch_stage handshake, stall, redirect, wrap and reset
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  int          n_checks = 0;
  int          n_fail = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_opcode(id_opcode), .id_funct(id_funct)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
    step(); step();
    check("rst_valid", {31'b0, id_valid}, 0);
    check("rst_req", {31'b0, imem_req}, 0);
    check("rst_pc", id_pc, 0);
    check("rst_instr", id_instr, 0);
    reset = 1'b0;
    #1;
    check("first_addr", imem_addr, 32'h3000);
    check("first_req", {31'b0, imem_req}, 1);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      check("wait_noreq", {31'b0, imem_req}, 0);
      check("gap_valid", {31'b0, id_valid}, 0);
      imem_rvalid = 1'b1;
      imem_rdata = i == 0 ? 32'h2008_0005 : 32'hA000_0000 + i;
      step();
      imem_rvalid = 1'b0;
      check("line_valid", {31'b0, id_valid}, 1);
      check("line_pc", id_pc, pcs[i]);
      check("line_pc4", id_pc_plus4, pcs[i] + 4);
      check("line_next_addr", imem_addr, pcs[i] + 4);
      if (i == 0) begin
        check("opcode", {26'b0, id_opcode}, 32'h08);
        check("funct", {26'b0, id_funct}, 32'h05);
      end
    end
    id_stall = 1'b1;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBEEF_0010;
    check("stall_hold_pc", id_pc, 32'h300C);
    step();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("full_noreq", {31'b0, imem_req}, 0);
      check("full_hold_pc", id_pc, 32'h300C);
      check("full_hold_instr", id_instr, 32'hA000_0003);
      check("full_hold_valid", {31'b0, id_valid}, 1);
      if (i < 2) step();
    end
    id_stall = 1'b0;
    step();
    check("skid_valid", {31'b0, id_valid}, 1);
    check("skid_pc", id_pc, 32'h3010);
    check("skid_instr", id_instr, 32'hBEEF_0010);
    check("skid_pc4", id_pc_plus4, 32'h3014);
    check("after_skid_addr", imem_addr, 32'h3014);
    check("after_skid_req", {31'b0, imem_req}, 1);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("no_dup_valid", {31'b0, id_valid}, 0);
    redirect = 1'b1;
    redirect_pc = 32'h3103;
    step();
    redirect = 1'b0;
    check("kill_valid", {31'b0, id_valid}, 0);
    check("kill_noreq", {31'b0, imem_req}, 0);
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_DEAD;
    step();
    imem_rvalid = 1'b0;
    check("stale_valid", {31'b0, id_valid}, 0);
    check("redir_req", {31'b0, imem_req}, 1);
    check("redir_addr", imem_addr, 32'h3100);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    check("tgt_pc", id_pc, 32'h3100);
    check("tgt_instr", id_instr, 32'h1234_5678);
    id_stall = 1'b1;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h5555_5555;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    check("pre_flush_valid", {31'b0, id_valid}, 1);
    step();
    imem_rvalid = 1'b0;
    redirect = 1'b0;
    id_stall = 1'b0;
    check("flush_valid", {31'b0, id_valid}, 0);
    check("flush_req", {31'b0, imem_req}, 1);
    check("flush_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0F0F_0F0F;
    step();
    imem_rvalid = 1'b0;
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc_plus4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    id_stall = 1'b1;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("pre_rst_valid", {31'b0, id_valid}, 1);
    reset = 1'b1;
    #1;
    check("arst_valid", {31'b0, id_valid}, 0);
    check("arst_pc", id_pc, 0);
    check("arst_pc4", id_pc_plus4, 0);
    check("arst_instr", id_instr, 0);
    check("arst_req", {31'b0, imem_req}, 0);
    step();
    reset = 1'b0;
    id_stall = 1'b0;
    #1;
    check("refetch_addr", imem_addr, 32'h3000);
    check("refetch_req", {31'b0, imem_req}, 1);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h2008_0005;
    step();
    imem_rvalid = 1'b0;
    check("refetch_pc", id_pc, 32'h3000);
    check("refetch_valid", {31'b0, id_valid}, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register, directly upstream of the decode traits logic.
- Maintains the PC and issues single-outstanding requests to instruction memory over a req/ack plus rvalid handshake.
- Delivers each fetched instruction, with its PC, PC+4, opcode and funct fields, to the ID stage.
- Honours ID back-pressure (stall) and control-flow redirects from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
IMEM_AW, 32, instruction address width (PC width)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  IMEM_AW  fetch address, word aligned
imem_ack  in  1  memory accepted the request this cycle
imem_rvalid  in  1  read data valid; at least 1 cycle after ack
imem_rdata  in  32  instruction word
id_stall  in  1  ID cannot accept this cycle
redirect  in  1  control-flow change; flush fetch and IF/ID
redirect_pc  in  IMEM_AW  redirect target; bits [1:0] ignored (treated as 0)
id_valid  out  1  IF/ID holds a live instruction
id_instr  out  32  instruction
id_pc  out  IMEM_AW  instruction address
id_pc_plus4  out  IMEM_AW  id_pc+4, wraps mod 2^IMEM_AW
id_opcode  out  6  id_instr[31:26]
id_funct  out  6  id_instr[5:0]

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - While reset is high: state=FETCH, pc=RESET_PC, kill=0, skid empty, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, imem_req=0.
- Outputs:
  - imem_req=1 only in FETCH with reset low.
  - imem_addr=pc, with bits [1:0] forced to 0.
  - id_opcode and id_funct are combinational slices of id_instr.
- Consume rule: ID takes IF/ID when id_valid && !id_stall. IF/ID "can load" when !id_valid || !id_stall.
- FSM, FETCH:
  - Hold imem_req until imem_ack.
  - On ack go to WAIT. pc is not advanced until the data lands.
- FSM, WAIT:
  - On rvalid with kill=1: discard the data, clear kill, go to FETCH.
  - On rvalid with kill=0 and can-load: load IF/ID with {rdata, pc, pc+4}, set id_valid=1, pc<=pc+4, go to FETCH.
  - On rvalid with kill=0 and cannot load: capture into the skid buffer, pc<=pc+4, go to FULL.
- FSM, FULL:
  - No requests are issued.
  - When !id_stall, move skid into IF/ID (id_valid stays 1) and go to FETCH.
- IF/ID hold and drain:
  - If IF/ID is consumed and nothing new loads, id_valid<=0 next edge.
  - While id_stall=1 with id_valid=1, all id_* outputs hold stable.
- Redirect (highest priority, any state):
  - Next edge: pc<=redirect_pc, id_valid<=0, skid emptied.
  - In FETCH without ack this cycle: the request is not accepted, so the next cycle re-requests at the new pc.
  - In FETCH with ack in the same cycle: go to WAIT with kill=1.
  - In WAIT without rvalid: kill<=1, stay in WAIT.
  - In WAIT with rvalid in the same cycle: drop the data, go to FETCH.
  - In FULL: go to FETCH.
  - Redirect and id_stall together: the redirect wins. IF/ID is flushed regardless of stall.
- Throughput: at most one outstanding request. Best case is one instruction per 2 cycles with 1-cycle memory (ack cycle, rvalid cycle).
- Arithmetic: pc+4 wraps modulo 2^IMEM_AW (32'hFFFF_FFFC+4 = 0).
- Reset mid-operation: any pending response is lost. Any imem_rvalid arriving after reset deasserts while in FETCH is ignored; the memory must not issue unmatched rvalid.
- Assertions for verification:
  - imem_addr is stable while imem_req && !imem_ack.
  - No imem_req while in WAIT or FULL.

Test Plan:
- Reset release, memory acks immediately, rvalid 1 cycle later with 32'h2008_0005 → imem_addr=32'h3000; then id_valid=1, id_pc=32'h3000, id_pc_plus4=32'h3004, id_opcode=6'b001000, id_funct=6'b000101; next imem_addr=32'h3004.
- Straight line, 4 fetches, no stall → id_pc sequence 3000/3004/3008/300C, each valid for 1 cycle, alternating with id_valid=0.
- id_stall held 5 cycles while the second instruction returns → first instruction held stable, second captured in skid (FULL, imem_req=0); on release, second appears next cycle; no instruction lost or duplicated.
- Redirect to 32'h3103 while in WAIT, rvalid 2 cycles later → stale data discarded, id_valid stays 0, next imem_addr=32'h3100.
- Redirect in the same cycle as rvalid and id_stall=1 with id_valid=1 → IF/ID flushed (id_valid=0), data dropped, next request to the target.
- pc=32'hFFFF_FFFC fetch → id_pc_plus4=0, next imem_addr=0. Separately, assert reset during WAIT → all outputs at reset values immediately, refetch from 32'h3000.
